// File: rtl/boot_ctrl.sv
// boot_ctrl: streams a length-prefixed image into instruction memory,
// then releases and supervises the CPU. Optional BOOT_CHECKSUM_EN adds a checksum byte.
module boot_ctrl #(
  parameter int unsigned MAX_WORDS = 32768,
  parameter int unsigned WATCHDOG  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [14:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  input  logic        cpu_halt,
  input  logic [15:0] cpu_pc,
  output logic [1:0]  state,
  output logic [31:0] cycle_count,
  output logic [15:0] halt_pc,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    P_HDR_HI = 3'd0,
    P_HDR_LO = 3'd1,
    P_DAT_HI = 3'd2,
    P_DAT_LO = 3'd3,
    P_WR     = 3'd4,
    P_CSUM   = 3'd5
  } phase_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t POST_STATE = S_LOAD;
  localparam phase_t POST_PHASE = P_CSUM;
`else
  localparam state_t POST_STATE = S_RUN;
  localparam phase_t POST_PHASE = P_HDR_HI;
`endif

  localparam bit WD_EN = (WATCHDOG != 0);

  state_t      state_q;
  state_t      state_d;
  phase_t      phase_q;
  phase_t      phase_d;
  logic [7:0]  hdr_hi_q;
  logic [7:0]  dat_hi_q;
  logic [15:0] words_left_q;
  logic        done_rst_q;

  logic        accept;
  logic        go;
  logic [15:0] hdr_n;
  logic        too_big;
  logic        last_word;
  logic        wd_hit;
  logic        run_entry;
  logic        err_set;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q;
  logic [7:0]  csum_total;
  logic        csum_ok;

  assign csum_total = csum_q + rx_data;
  assign csum_ok    = (csum_total == 8'h00);
`endif

  assign accept    = rx_valid & rx_ready;
  assign go        = start &
                     ((state_q == S_IDLE) |
                      (state_q == S_DONE));
  assign hdr_n     = {hdr_hi_q, rx_data};
  assign too_big   = 32'(hdr_n) > MAX_WORDS;
  assign last_word = (words_left_q == 16'd1);
  assign wd_hit    = WD_EN &&
                     (cycle_count >= WATCHDOG);
  assign run_entry = (state_q != S_RUN) &&
                     (state_d == S_RUN);
  assign state     = state_q;

  // Error sources: oversized header, bad checksum, watchdog expiry
  always_comb begin
    err_set = 1'b0;
    unique case (1'b1)
      state_q == S_LOAD: begin
        if (accept && phase_q == P_HDR_LO)
          err_set = too_big;
`ifdef BOOT_CHECKSUM_EN
        if (accept && phase_q == P_CSUM)
          err_set = !csum_ok;
`endif
      end
      state_q == S_RUN:
        err_set = !cpu_halt && wd_hit;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= P_HDR_HI;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state: top-level state plus load sub-phase
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          phase_d = P_HDR_HI;
        end
      end
      S_LOAD: begin
        case (phase_q)
          P_HDR_HI: begin
            if (accept)
              phase_d = P_HDR_LO;
          end
          P_HDR_LO: begin
            if (accept) begin
              if (too_big) begin
                state_d = S_IDLE;
                phase_d = P_HDR_HI;
              end else if (hdr_n == 16'd0) begin
                state_d = POST_STATE;
                phase_d = POST_PHASE;
              end else begin
                phase_d = P_DAT_HI;
              end
            end
          end
          P_DAT_HI: begin
            if (accept)
              phase_d = P_DAT_LO;
          end
          P_DAT_LO: begin
            if (accept)
              phase_d = P_WR;
          end
          P_WR: begin
            if (last_word) begin
              state_d = POST_STATE;
              phase_d = POST_PHASE;
            end else begin
              phase_d = P_DAT_HI;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          P_CSUM: begin
            if (accept) begin
              state_d = csum_ok ? S_RUN : S_IDLE;
              phase_d = P_HDR_HI;
            end
          end
`endif
          default: phase_d = P_HDR_HI;
        endcase
      end
      S_RUN: begin
        if (cpu_halt || wd_hit)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; DONE keeps the reset level it entered with
  always_comb begin
    rx_ready  = 1'b0;
    cpu_reset = 1'b1;
    unique case (1'b1)
      state_q == S_LOAD:
        rx_ready = (phase_q != P_WR);
      state_q == S_RUN:
        cpu_reset = 1'b0;
      state_q == S_DONE:
        cpu_reset = done_rst_q;
      default: ;
    endcase
  end

  // Load datapath: header capture, word assembly, memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi_q     <= 8'h00;
      dat_hi_q     <= 8'h00;
      words_left_q <= 16'd0;
      imem_we      <= 1'b0;
      imem_addr    <= 15'd0;
      imem_wdata   <= 16'h0000;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      imem_we <= 1'b0;
      if (go) begin
        imem_addr <= 15'd0;
`ifdef BOOT_CHECKSUM_EN
        csum_q    <= 8'h00;
`endif
      end
      if (state_q == S_LOAD) begin
        case (phase_q)
          P_HDR_HI: begin
            if (accept)
              hdr_hi_q <= rx_data;
          end
          P_HDR_LO: begin
            if (accept)
              words_left_q <= hdr_n;
          end
          P_DAT_HI: begin
            if (accept) begin
              dat_hi_q <= rx_data;
`ifdef BOOT_CHECKSUM_EN
              csum_q   <= csum_total;
`endif
            end
          end
          P_DAT_LO: begin
            if (accept) begin
              imem_we    <= 1'b1;
              imem_wdata <= {dat_hi_q, rx_data};
`ifdef BOOT_CHECKSUM_EN
              csum_q     <= csum_total;
`endif
            end
          end
          P_WR: begin
            imem_addr    <= imem_addr + 15'd1;
            words_left_q <= words_left_q - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Run supervision: cycle counter, halt capture, reset level for DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 32'd0;
      halt_pc     <= 16'h0000;
      done_rst_q  <= 1'b1;
    end else if (run_entry) begin
      cycle_count <= 32'd0;
    end else if (state_q == S_RUN) begin
      if (cpu_halt) begin
        halt_pc    <= cpu_pc;
        done_rst_q <= 1'b0;
      end else if (wd_hit) begin
        done_rst_q <= 1'b1;
      end else if (cycle_count != 32'hFFFF_FFFF) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

  // Sticky error flag, cleared only by an accepted start
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (go)
      err <= 1'b0;
    else if (err_set)
      err <= 1'b1;
  end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 32768: the largest accepted image length in 16-bit words.
REQ-002 The block SHALL have parameter WATCHDOG, default 0: the RUN-cycle limit, where 0 disables the watchdog.
REQ-003 The block SHALL have port clk  input  1  system clock, sampled on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin an image load.
REQ-006 The block SHALL have ports rx_data  input  8, rx_valid  input  1 and rx_ready  output  1, forming the byte stream; a byte transfers on a cycle where rx_valid and rx_ready are both 1.
REQ-007 The block SHALL have ports imem_we  output  1, imem_addr  output  15 (word address) and imem_wdata  output  16, forming the instruction-memory write port.
REQ-008 The block SHALL have ports cpu_reset  output  1 (CPU held in reset while 1), cpu_halt  input  1 and cpu_pc  input  16.
REQ-009 The block SHALL have ports state  output  2 (IDLE=0, LOAD=1, RUN=2, DONE=3), cycle_count  output  32, halt_pc  output  16 and err  output  1.

Function
REQ-010 IDLE: cpu_reset=1 and rx_ready=0; start moves to LOAD and clears err.
REQ-011 LOAD, header: rx_ready=1; the first two accepted bytes form word count N, high byte first.
REQ-012 Header: N > MAX_WORDS sets err=1 and returns to IDLE; N=0 goes straight to the post-image step (REQ-015).
REQ-013 LOAD, data: each word is a high byte followed by a low byte; imem_wdata={hi,lo}.
REQ-014 Data: imem_we pulses for exactly 1 cycle, in the cycle after the low byte is accepted; imem_addr starts at 0 and increments by 1 after each write.
REQ-015 After word N is written, the block SHALL enter RUN one cycle after that write, with rx_ready=0.
REQ-016 RUN: cpu_reset=0 from the first RUN cycle onward; cycle_count resets to 0 on entry and increments by 1 each RUN cycle, saturating at 32'hFFFFFFFF.
REQ-017 RUN: cpu_halt=1 moves to DONE on the next edge; halt_pc captures cpu_pc from that cycle; cycle_count freezes.
REQ-018 RUN: if WATCHDOG!=0 and cycle_count reaches WATCHDOG with cpu_halt=0, the block SHALL set err=1 and enter DONE with cpu_reset=1.
REQ-019 If cpu_halt and the watchdog limit occur in the same cycle, halt SHALL take priority and err SHALL stay 0.
REQ-020 DONE: rx_ready=0 and imem_we=0; cpu_reset keeps its value from entry.
REQ-021 start in LOAD or RUN SHALL be ignored.
REQ-022 start in DONE moves to LOAD, asserts cpu_reset in the same cycle, clears err, and resets imem_addr to 0.
REQ-023 err SHALL be sticky until the next accepted start or reset.
REQ-024 rx_valid=0 mid-word SHALL stall the block with no timeout and no partial write.

Reset
REQ-025 On reset the block SHALL set state=IDLE, cpu_reset=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cycle_count=0, halt_pc=0 and err=0.
REQ-026 Reset mid-LOAD SHALL abandon the image, suppress any pending imem_we, and leave already-written words unchanged.

Configuration
REQ-027 With BOOT_CHECKSUM_EN defined, LOAD SHALL accept one extra byte after word N; the image is valid when the 8-bit sum (mod 256) of all data bytes plus this byte equals 0.
REQ-028 With BOOT_CHECKSUM_EN defined, a valid image SHALL enter RUN; a mismatch SHALL set err=1 and return to IDLE with cpu_reset=1.
REQ-029 Without BOOT_CHECKSUM_EN, no checksum byte is expected and RUN follows word N per REQ-015.

Verification
REQ-030 The bench SHALL cover: start, then bytes 00 02 30 40 FF FF -> writes addr0=3040 and addr1=FFFF, each imem_we exactly 1 cycle; RUN; cpu_reset falls.
REQ-031 The bench SHALL cover: in RUN, cpu_halt raised on the 10th RUN cycle with cpu_pc=000A -> DONE, halt_pc=000A, cycle_count frozen at 9.
REQ-032 The bench SHALL cover: header 80 01 with MAX_WORDS=32768 -> err=1, IDLE, no imem_we.
REQ-033 The bench SHALL cover: WATCHDOG=100 with cpu_halt held 0 -> DONE after cycle_count=100, err=1, cpu_reset=1.
REQ-034 The bench SHALL cover: with BOOT_CHECKSUM_EN defined, bytes 00 01 12 34 BA -> RUN; the same image with checksum BB -> err=1, IDLE.
REQ-035 The bench SHALL cover: reset asserted after the high byte of word 0 -> no write, IDLE; a following start with 00 00 -> RUN immediately.
